openrisc_sopc: RTL and testbench
================================

OPENRISC_SOPC -- requirements
Module: openrisc_sopc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; every register and both SRAMs are clocked on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port timer_irq_i, input, 1 bit: level-sensitive timer interrupt request.
REQ-004 SHALL have port dbg_pc_o, output, 32 bits: PC of the instruction currently executing.
REQ-005 SHALL have port dbg_wb_we_o, output, 1 bit: one-cycle pulse when a GPR is written.
REQ-006 SHALL have port dbg_wb_addr_o, output, 5 bits: destination GPR index of that write.
REQ-007 SHALL have port dbg_wb_data_o, output, 32 bits: data of that write.
REQ-008 SHALL have no parameters and no separate SRAM clock.

Function
REQ-009 SHALL contain instance u_openriscv, an RV32 multicycle core, with register file u_openriscv.u_regfile whose array gpr_regs is 32x32 bits and preloadable by $readmemh.
REQ-010 SHALL contain instruction SRAM u1_ahb_sram and data SRAM u2_ahb_sram, each built as bank0[0..3].u_sram_8kx8.mem (8192x8 each), all preloadable.
REQ-011 SHALL store byte k of each little-endian word in bank k, indexed by addr[14:2].
REQ-012 SHALL decode addresses as: addr[16]=0 selects instruction SRAM (byte range 0x0000-0x7FFF); addr[16]=1 selects data SRAM (byte range 0x10000-0x17FFF).
REQ-013 SHALL read SRAMs synchronously: address presented in cycle N, data usable in cycle N+1.
REQ-014 SHALL run a state machine IF -> EX -> (MEM) -> WB -> IF: ALU, LUI, branch and JAL take 3 cycles; LW and SW take 4 cycles.
REQ-015 SHALL support ADDI, ADD, SUB, AND, OR, XOR, SLT, LUI, LW, SW, BEQ, BNE, JAL and MRET.
REQ-016 SHALL use 32-bit wrap-around arithmetic; SLT is signed.
REQ-017 SHALL treat every other encoding as a NOP: PC+4 with no state change.
REQ-018 SHALL always read x0 as 0 and discard any write to x0, with no dbg_wb_we_o pulse.
REQ-019 SHALL ignore addr[1:0] for LW and SW, i.e. word access only.
REQ-020 SHALL make SW write all 4 banks in MEM, and SHALL NOT write to the instruction SRAM in that case.
REQ-021 SHALL assert dbg_wb_we_o only in WB, for ALU, LUI, LW and JAL results; JAL writes rd=PC+4.
REQ-022 SHALL take a taken branch or JAL target as PC+imm, and otherwise advance to PC+4.
REQ-023 SHALL keep an internal mie flag (reset 1) and mepc register.
REQ-024 SHALL enter a trap on entry to IF when timer_irq_i=1 and mie=1: mepc<=next PC, PC<=0x40, mie<=0.
REQ-025 SHALL apply an interrupt only at the instruction boundary, never mid-instruction.
REQ-026 SHALL make MRET (0x30200073) load PC<=mepc and set mie<=1.

Reset
REQ-027 SHALL on rst=1 at a clock edge set PC=0, state=IF, mie=1, mepc=0 and all dbg outputs to 0.
REQ-028 SHALL abort any in-flight instruction when rst asserts: a pending SW writes nothing and there is no WB.
REQ-029 SHALL NOT clear GPR or SRAM contents on reset.
REQ-030 SHALL begin fetching at address 0 on the first edge after rst deasserts.

Verification
REQ-031 SHALL pass this case: ROM word0 = ADDI x1,x0,5 -> 3 cycles after reset release, dbg_wb_we_o=1, addr=1, data=5.
REQ-032 SHALL pass this case: ADDI x1,x0,-1, then ADDI x1,x1,1 -> second writeback data=0 (wrap).
REQ-033 SHALL pass this case: LUI x2,0x10; SW x1,0(x2); LW x3,0(x2) with x1=0x11223344 -> data bank0=0x44, bank3=0x11, x3 writeback 0x11223344.
REQ-034 SHALL pass this case: BEQ x0,x0,+8 at PC 0 -> next dbg_pc_o=8, with no writeback pulse.
REQ-035 SHALL pass this case: timer_irq_i=1 during ADDI at PC 4 -> next dbg_pc_o=0x40; MRET at 0x40 -> dbg_pc_o=8; a second irq is taken only after MRET.
REQ-036 SHALL pass this case: rst pulse asserted while in MEM of an SW -> data SRAM unchanged and dbg_pc_o=0.

Source files
------------

// File: rtl/openrisc_sopc_if.sv
// Core-to-memory bus: byte address, write data/enable and one-cycle-late read data.
interface openrisc_sopc_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/openrisc_sopc.sv
// OpenRISC SoPC: RV32 multicycle core, instruction SRAM (addr[16]=0) and data SRAM (addr[16]=1).

// 8K x 8 synchronous SRAM bank, preloadable through mem.
module sram_8kx8 (
    input  logic        clk,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata
);
    logic [7:0] mem [0:8191];

    // Write-first-free synchronous port: read data appears the cycle after the address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// 32-bit word SRAM built from four byte banks; byte k of a word lives in bank k.
module ahb_sram (
    input  logic        clk,
    input  logic [12:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata
);
    for (genvar k = 0; k < 4; k++) begin : bank0
        sram_8kx8 u_sram_8kx8 (
            .clk   (clk),
            .addr  (addr),
            .wdata (wdata[8*k +: 8]),
            .we    (we),
            .rdata (rdata[8*k +: 8])
        );
    end
endmodule

// 32 x 32 general purpose registers; x0 reads as zero and is never written.
module openriscv_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] gpr_regs [0:31];

    // Single write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            gpr_regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : gpr_regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : gpr_regs[raddr2];
endmodule

// Multicycle RV32 subset core: IF -> EX -> (MEM) -> WB -> IF.
module openriscv (
    input  logic            clk,
    input  logic            rst,
    input  logic            timer_irq_i,
    openrisc_sopc_if.master bus,
    output logic [31:0]     dbg_pc_o,
    output logic            dbg_wb_we_o,
    output logic [4:0]      dbg_wb_addr_o,
    output logic [31:0]     dbg_wb_data_o
);
    typedef enum logic [1:0] {S_IF = 2'd0, S_EX = 2'd1, S_MEM = 2'd2, S_WB = 2'd3} state_t;
    localparam logic [31:0] MRET_INSN = 32'h3020_0073;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0040;

    state_t      state, state_nx;
    logic [31:0] pc, npc, mepc, st_addr, st_data;
    logic        mie, ld_flag, mret_flag;
    logic [4:0]  ld_rd;
    logic [31:0] ir, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_j, alu, ex_npc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  op, f7;
    logic        wr_ok, is_ld, is_st, is_mret, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // The instruction is only meaningful in EX, the cycle after its fetch address.
    assign ir    = bus.rdata;
    assign op    = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign f7    = ir[31:25];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign dbg_pc_o = pc;

    openriscv_regfile u_regfile (
        .clk    (clk),
        .we     (wr_en),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_v),
        .rdata2 (rs2_v)
    );

    // Decode and execute; anything not recognised falls through as a NOP.
    always_comb begin
        alu     = 32'd0;
        wr_ok   = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_mret = 1'b0;
        ex_npc  = pc + 32'd4;
        case (op)
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    alu = rs1_v + imm_i; wr_ok = 1'b1;
                end else begin
                    wr_ok = 1'b0;
                end
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  begin alu = rs1_v + rs2_v; wr_ok = 1'b1; end
                        3'b111:  begin alu = rs1_v & rs2_v; wr_ok = 1'b1; end
                        3'b110:  begin alu = rs1_v | rs2_v; wr_ok = 1'b1; end
                        3'b100:  begin alu = rs1_v ^ rs2_v; wr_ok = 1'b1; end
                        3'b010:  begin alu = {31'd0, ($signed(rs1_v) < $signed(rs2_v))}; wr_ok = 1'b1; end
                        default: wr_ok = 1'b0;
                    endcase
                end else if ((f7 == 7'b0100000) && (f3 == 3'b000)) begin
                    alu = rs1_v - rs2_v; wr_ok = 1'b1;
                end else begin
                    wr_ok = 1'b0;
                end
            end
            7'b0110111: begin alu = {ir[31:12], 12'd0}; wr_ok = 1'b1; end
            7'b1101111: begin alu = pc + 32'd4; wr_ok = 1'b1; ex_npc = pc + imm_j; end
            7'b1100011: begin
                if (((f3 == 3'b000) && (rs1_v == rs2_v)) || ((f3 == 3'b001) && (rs1_v != rs2_v))) begin
                    ex_npc = pc + imm_b;
                end else begin
                    ex_npc = pc + 32'd4;
                end
            end
            7'b0000011: is_ld = (f3 == 3'b010);
            7'b0100011: is_st = (f3 == 3'b010);
            7'b1110011: begin
                if (ir == MRET_INSN) begin
                    is_mret = 1'b1; ex_npc = mepc;
                end else begin
                    is_mret = 1'b0;
                end
            end
            default: alu = 32'd0;
        endcase
    end

    // Next state, bus drive and GPR write port; reset suppresses any store or writeback.
    always_comb begin
        state_nx  = S_IF;
        bus.addr  = pc;
        bus.wdata = st_data;
        bus.we    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = ld_rd;
        wr_data   = bus.rdata;
        case (state)
            S_IF:  state_nx = S_EX;
            S_EX: begin
                state_nx = (is_ld || is_st) ? S_MEM : S_WB;
                if (is_ld) begin
                    bus.addr = rs1_v + imm_i;
                end else begin
                    bus.addr = pc;
                end
                wr_addr = rd;
                wr_data = alu;
                wr_en   = wr_ok && (rd != 5'd0) && !rst;
            end
            S_MEM: begin
                state_nx = S_WB;
                bus.addr = st_addr;
                bus.we   = !ld_flag && !rst;
                wr_en    = ld_flag && (ld_rd != 5'd0) && !rst;
            end
            S_WB:    state_nx = S_IF;
            default: state_nx = S_IF;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            state <= state_nx;
        end
    end

    // PC, trap/return bookkeeping, memory-stage operands and debug writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0; npc <= 32'd0; mepc <= 32'd0; mie <= 1'b1;
            st_addr <= 32'd0; st_data <= 32'd0; ld_flag <= 1'b0; ld_rd <= 5'd0; mret_flag <= 1'b0;
            dbg_wb_we_o <= 1'b0; dbg_wb_addr_o <= 5'd0; dbg_wb_data_o <= 32'd0;
        end else begin
            dbg_wb_we_o <= wr_en;
            if (wr_en) begin
                dbg_wb_addr_o <= wr_addr;
                dbg_wb_data_o <= wr_data;
            end
            case (state)
                S_EX: begin
                    npc <= ex_npc; ld_flag <= is_ld; ld_rd <= rd; mret_flag <= is_mret;
                    st_addr <= rs1_v + imm_s; st_data <= rs2_v;
                end
                S_WB: begin
                    // Interrupts are only taken here, between instructions.
                    if (timer_irq_i && mie) begin
                        mepc <= npc; pc <= TRAP_VEC; mie <= 1'b0;
                    end else begin
                        pc <= npc;
                        if (mret_flag) begin
                            mie <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// Top level: core plus address decode between the two SRAMs.
module openrisc_sopc (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_irq_i,
    output logic [31:0] dbg_pc_o,
    output logic        dbg_wb_we_o,
    output logic [4:0]  dbg_wb_addr_o,
    output logic [31:0] dbg_wb_data_o
);
    openrisc_sopc_if core_bus ();
    logic [31:0] irom_rdata, dram_rdata;
    logic        dsel_r, dram_we;
    logic        unused_addr_bits;

    openriscv u_openriscv (
        .clk           (clk),
        .rst           (rst),
        .timer_irq_i   (timer_irq_i),
        .bus           (core_bus),
        .dbg_pc_o      (dbg_pc_o),
        .dbg_wb_we_o   (dbg_wb_we_o),
        .dbg_wb_addr_o (dbg_wb_addr_o),
        .dbg_wb_data_o (dbg_wb_data_o)
    );

    // Stores only ever reach the data SRAM; the instruction SRAM is read-only to the core.
    assign dram_we = core_bus.we & core_bus.addr[16];
    assign unused_addr_bits = ^{core_bus.addr[31:17], core_bus.addr[15], core_bus.addr[1:0]};

    ahb_sram u1_ahb_sram (
        .clk (clk), .addr (core_bus.addr[14:2]), .wdata (core_bus.wdata), .we (1'b0), .rdata (irom_rdata)
    );
    ahb_sram u2_ahb_sram (
        .clk (clk), .addr (core_bus.addr[14:2]), .wdata (core_bus.wdata), .we (dram_we), .rdata (dram_rdata)
    );

    // Remember which SRAM was addressed so its read data is selected one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsel_r <= 1'b0;
        end else begin
            dsel_r <= core_bus.addr[16];
        end
    end

    assign core_bus.rdata = dsel_r ? dram_rdata : irom_rdata;
endmodule

// File: tb/tb_openrisc_sopc.sv
// Self-checking bench for openrisc_sopc: writebacks are scored against an expected queue.
module tb_openrisc_sopc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        timer_irq_i = 1'b0;
    logic [31:0] dbg_pc_o;
    logic        dbg_wb_we_o;
    logic [4:0]  dbg_wb_addr_o;
    logic [31:0] dbg_wb_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [4:0] a; logic [31:0] d; } wb_t;
    wb_t exp_q[$];

    openrisc_sopc dut (
        .clk (clk), .rst (rst), .timer_irq_i (timer_irq_i), .dbg_pc_o (dbg_pc_o),
        .dbg_wb_we_o (dbg_wb_we_o), .dbg_wb_addr_o (dbg_wb_addr_o), .dbg_wb_data_o (dbg_wb_data_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        logic [31:0] v; v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [31:0] v; v = imm;
        return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        logic [31:0] v; v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input int imm);
        logic [31:0] v; v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    task automatic rom_put(input int idx, input logic [31:0] w);
        dut.u1_ahb_sram.bank0[0].u_sram_8kx8.mem[idx] = w[7:0];
        dut.u1_ahb_sram.bank0[1].u_sram_8kx8.mem[idx] = w[15:8];
        dut.u1_ahb_sram.bank0[2].u_sram_8kx8.mem[idx] = w[23:16];
        dut.u1_ahb_sram.bank0[3].u_sram_8kx8.mem[idx] = w[31:24];
    endtask
    task automatic ram_put(input int idx, input logic [31:0] w);
        dut.u2_ahb_sram.bank0[0].u_sram_8kx8.mem[idx] = w[7:0];
        dut.u2_ahb_sram.bank0[1].u_sram_8kx8.mem[idx] = w[15:8];
        dut.u2_ahb_sram.bank0[2].u_sram_8kx8.mem[idx] = w[23:16];
        dut.u2_ahb_sram.bank0[3].u_sram_8kx8.mem[idx] = w[31:24];
    endtask
    function automatic logic [31:0] ram_get(input int idx);
        return {dut.u2_ahb_sram.bank0[3].u_sram_8kx8.mem[idx], dut.u2_ahb_sram.bank0[2].u_sram_8kx8.mem[idx],
                dut.u2_ahb_sram.bank0[1].u_sram_8kx8.mem[idx], dut.u2_ahb_sram.bank0[0].u_sram_8kx8.mem[idx]};
    endfunction
    function automatic logic [31:0] rom_get(input int idx);
        return {dut.u1_ahb_sram.bank0[3].u_sram_8kx8.mem[idx], dut.u1_ahb_sram.bank0[2].u_sram_8kx8.mem[idx],
                dut.u1_ahb_sram.bank0[1].u_sram_8kx8.mem[idx], dut.u1_ahb_sram.bank0[0].u_sram_8kx8.mem[idx]};
    endfunction

    task automatic exp_wb(input logic [4:0] a, input logic [31:0] d);
        wb_t e; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // Hold reset, clear program space and check the reset state of the debug outputs.
    task automatic start_reset();
        rst = 1'b1;
        timer_irq_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_pc", dbg_pc_o, 32'd0);
        check_val("rst_we", {31'd0, dbg_wb_we_o}, 32'd0);
        check_val("rst_waddr", {27'd0, dbg_wb_addr_o}, 32'd0);
        check_val("rst_wdata", dbg_wb_data_o, 32'd0);
        for (int i = 0; i < 128; i++) rom_put(i, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
        int n = 0;
        while ((dbg_pc_o !== target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, dbg_pc_o, target);
    endtask

    task automatic wait_pc_change(input string tag, input logic [31:0] expect_pc, input int budget);
        logic [31:0] old;
        int n = 0;
        old = dbg_pc_o;
        while ((dbg_pc_o === old) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, dbg_pc_o, expect_pc);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check_val(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard: every writeback pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (dbg_wb_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("wb_unexpected_rd", {27'd0, dbg_wb_addr_o}, 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check_val("wb_rd", {27'd0, dbg_wb_addr_o}, {27'd0, e.a});
                check_val("wb_data", dbg_wb_data_o, e.d);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x1, x5;
        // --- Test 1: first writeback latency and wrap-around
        start_reset();
        rom_put(0, addi(5'd1, 5'd0, 5));
        rom_put(1, addi(5'd1, 5'd0, -1));
        rom_put(2, addi(5'd1, 5'd1, 1));
        exp_wb(5'd1, 32'd5); exp_wb(5'd1, 32'hFFFF_FFFF); exp_wb(5'd1, 32'd0);
        release_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_val("first_wb_we", {31'd0, dbg_wb_we_o}, 32'd1);
        check_val("first_wb_pc", dbg_pc_o, 32'd0);
        wait_pc("t1_end", 32'd12, 40);
        drain("t1_drain");

        // --- Test 2: ALU ops, memory, branches, JAL, NOP, x0
        x1 = 32'h1122_3344;
        x5 = 32'd0 - x1;
        start_reset();
        rom_put(0,  lui(5'd1, 20'h11223));
        rom_put(1,  addi(5'd1, 5'd1, 32'h344));
        rom_put(2,  lui(5'd2, 20'h00010));
        rom_put(3,  sw(5'd1, 5'd2, 0));
        rom_put(4,  lw(5'd3, 5'd2, 0));
        rom_put(5,  rtype(7'h00, 3'b000, 5'd4, 5'd3, 5'd1));
        rom_put(6,  rtype(7'h20, 3'b000, 5'd5, 5'd0, 5'd1));
        rom_put(7,  rtype(7'h00, 3'b010, 5'd6, 5'd5, 5'd1));
        rom_put(8,  rtype(7'h00, 3'b010, 5'd7, 5'd1, 5'd5));
        rom_put(9,  rtype(7'h00, 3'b111, 5'd8, 5'd1, 5'd5));
        rom_put(10, rtype(7'h00, 3'b110, 5'd9, 5'd1, 5'd5));
        rom_put(11, rtype(7'h00, 3'b100, 5'd10, 5'd1, 5'd5));
        rom_put(12, addi(5'd0, 5'd1, 1));
        rom_put(13, jal(5'd11, 8));
        rom_put(14, addi(5'd12, 5'd0, 7));
        rom_put(15, br(3'b001, 5'd1, 5'd0, 8));
        rom_put(16, addi(5'd13, 5'd0, 7));
        rom_put(17, br(3'b000, 5'd1, 5'd0, 8));
        rom_put(18, addi(5'd14, 5'd0, 9));
        rom_put(19, 32'hFFFF_FFFF);
        rom_put(20, addi(5'd15, 5'd0, 1));
        rom_put(21, sw(5'd1, 5'd0, 32'h100));
        rom_put(22, lw(5'd16, 5'd2, 3));
        ram_put(0, 32'd0);
        exp_wb(5'd1, 32'h1122_3000); exp_wb(5'd1, x1); exp_wb(5'd2, 32'h0001_0000);
        exp_wb(5'd3, x1); exp_wb(5'd4, 32'h2244_6688); exp_wb(5'd5, 32'hEEDD_CCBC);
        exp_wb(5'd6, 32'd1); exp_wb(5'd7, 32'd0);
        exp_wb(5'd8, x1 & x5); exp_wb(5'd9, x1 | x5); exp_wb(5'd10, x1 ^ x5);
        exp_wb(5'd11, 32'd56); exp_wb(5'd14, 32'd9); exp_wb(5'd15, 32'd1); exp_wb(5'd16, x1);
        release_reset();
        wait_pc("t2_end", 32'd92, 200);
        drain("t2_drain");
        check_val("sw_bank0", {24'd0, dut.u2_ahb_sram.bank0[0].u_sram_8kx8.mem[0]}, 32'h44);
        check_val("sw_bank3", {24'd0, dut.u2_ahb_sram.bank0[3].u_sram_8kx8.mem[0]}, 32'h11);
        check_val("sw_word", ram_get(0), x1);
        check_val("rom_untouched", rom_get(64), 32'd0);

        // --- Test 3: taken BEQ at PC 0 skips to 8 with no writeback
        start_reset();
        rom_put(0, br(3'b000, 5'd0, 5'd0, 8));
        rom_put(1, addi(5'd1, 5'd0, 2));
        rom_put(2, addi(5'd1, 5'd0, 1));
        exp_wb(5'd1, 32'd1);
        release_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("beq_pc", dbg_pc_o, 32'd8);
        wait_pc("t3_end", 32'd12, 20);
        drain("t3_drain");

        // --- Test 4: timer interrupt, MRET, and re-trap only after MRET
        start_reset();
        rom_put(0, addi(5'd1, 5'd0, 1));
        rom_put(1, addi(5'd2, 5'd0, 2));
        rom_put(2, addi(5'd3, 5'd0, 3));
        rom_put(3, addi(5'd4, 5'd0, 4));
        rom_put(16, 32'h3020_0073);
        exp_wb(5'd1, 32'd1); exp_wb(5'd2, 32'd2); exp_wb(5'd3, 32'd3); exp_wb(5'd4, 32'd4);
        release_reset();
        wait_pc("irq_pc4", 32'd4, 20);
        timer_irq_i = 1'b1;
        wait_pc_change("irq_vector", 32'h40, 20);
        wait_pc_change("mret_ret", 32'd8, 20);
        wait_pc_change("irq_again", 32'h40, 20);
        timer_irq_i = 1'b0;
        wait_pc_change("mret_ret2", 32'd12, 20);
        wait_pc("t4_end", 32'd16, 20);
        drain("t4_drain");

        // --- Test 5: reset during MEM of a store aborts it
        start_reset();
        rom_put(0, lui(5'd2, 20'h00010));
        rom_put(1, addi(5'd1, 5'd0, 32'h55));
        rom_put(2, sw(5'd1, 5'd2, 8));
        ram_put(2, 32'hA5A5_A5A5);
        exp_wb(5'd2, 32'h0001_0000); exp_wb(5'd1, 32'h55);
        release_reset();
        wait_pc("sw_pc8", 32'd8, 20);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("abort_pc", dbg_pc_o, 32'd0);
        check_val("abort_we", {31'd0, dbg_wb_we_o}, 32'd0);
        check_val("abort_ram", ram_get(2), 32'hA5A5_A5A5);
        drain("t5_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
